ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_loader_shreg.sv | 35 +++
 rtl/ccff_loader.sv | 213 +++++++++++++++++++++
 tb/tb_ccff_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Purpose: shared types and defaults for the configuration-chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ccff_loader_pkg;

  // Default bitstream / readback word width; the chain length stays a
  // parameter of the loader itself because it is fabric-specific.
  localparam int DEF_WORD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ccff_loader_shreg.sv
// Purpose: WORD_W parallel-load / serial-shift register (MSB leaves first, sin enters at LSB).
// Latency: load or shift takes effect on the next prog_clk rising edge.
// Backpressure: none; the owner decides when to load or shift.
//
// Ports: prog_clk/pReset clock and async active-low reset; load/load_val
// parallel load (wins over shift); shift/sin serial step; q full contents;
// msb the bit that would leave next.
module ccff_loader_shreg
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              shift,
  input  logic              sin,
  output logic [WORD_W-1:0] q,
  output logic              msb
);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= (q << 1) | WORD_W'(sin);
    end
  end

  assign msb = q[WORD_W-1];

endmodule

// File: rtl/ccff_loader.sv
// Purpose: loads a bitstream into a serial configuration chain, or reads it back nondestructively.
// Latency: a word accepted at cycle t drives ccff_head on shift cycles t+1..t+WORD_W; done one cycle after the last shift.
// Backpressure: cfg_ready is registered and only high when the bit buffer is empty; rb_valid has no backpressure.
//
// Ports: prog_clk, pReset (async active-low); start/readback request a pass
// from IDLE; cfg_data/cfg_valid/cfg_ready bitstream input; ccff_head,
// shift_en, ccff_tail chain interface; rb_data/rb_valid readback words;
// busy/done pass status.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              readback,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CHAIN_C  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] W_FULL   = PW'(WORD_W);
  localparam logic [PW-1:0] W_LAST   = PW'(WORD_W - 1);
  localparam logic [31:0]   WORD_W_U = WORD_W;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;         // shift cycles completed this pass
  logic [CW-1:0]     issued, issued_n;   // chain bits already handed to the serializer
  logic [PW-1:0]     pend, pend_n;       // bits still waiting behind the one on ccff_head
  logic [PW-1:0]     rcnt, rcnt_n;       // bits captured into the current readback word
  logic              head_q, head_n;
  logic              shift_en_n, cfg_ready_n, rb_valid_n, busy_n, done_n;
  logic [WORD_W-1:0] rb_data_n;

  logic [CW-1:0]     rem;
  logic [PW-1:0]     vb;                 // useful bits in the word being accepted
  logic [WORD_W-1:0] captured;

  logic              ser_load, ser_shift, ser_msb;
  logic [WORD_W-1:0] ser_word, ser_q_unused;
  logic              des_load, des_shift, des_msb_unused;
  logic [WORD_W-1:0] des_q;

  // The MSB goes straight to ccff_head on acceptance, so the serializer only
  // has to hold the bits behind it.
  assign ser_word = cfg_data << 1;

  ccff_loader_shreg #(.WORD_W(WORD_W)) u_ser (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .load     (ser_load),
    .load_val (ser_word),
    .shift    (ser_shift),
    .sin      (1'b0),
    .q        (ser_q_unused),
    .msb      (ser_msb)
  );

  ccff_loader_shreg #(.WORD_W(WORD_W)) u_des (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .load     (des_load),
    .load_val ({WORD_W{1'b0}}),
    .shift    (des_shift),
    .sin      (ccff_tail),
    .q        (des_q),
    .msb      (des_msb_unused)
  );

  // During readback the tail is looped straight back into the head so the
  // chain ends the pass holding exactly what it started with.
  assign ccff_head = (state == ST_READ) ? ccff_tail : head_q;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      issued    <= '0;
      pend      <= '0;
      rcnt      <= '0;
      head_q    <= 1'b0;
      shift_en  <= 1'b0;
      cfg_ready <= 1'b0;
      rb_valid  <= 1'b0;
      rb_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      issued    <= issued_n;
      pend      <= pend_n;
      rcnt      <= rcnt_n;
      head_q    <= head_n;
      shift_en  <= shift_en_n;
      cfg_ready <= cfg_ready_n;
      rb_valid  <= rb_valid_n;
      rb_data   <= rb_data_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    issued_n   = issued;
    pend_n     = pend;
    rcnt_n     = rcnt;
    head_n     = head_q;
    shift_en_n = 1'b0;
    rb_valid_n = 1'b0;
    rb_data_n  = rb_data;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    des_load   = 1'b0;
    des_shift  = 1'b0;

    // Final word of a chain that is not a word multiple only carries its
    // top rem bits; the rest are never counted into pend.
    rem      = CHAIN_C - issued;
    vb       = (32'(rem) >= WORD_W_U) ? W_FULL : PW'(rem);
    captured = (des_q << 1) | WORD_W'(ccff_tail);

    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_n    = '0;
          issued_n = '0;
          pend_n   = '0;
          rcnt_n   = '0;
          if (readback) begin
            state_n    = ST_READ;
            shift_en_n = 1'b1;
            des_load   = 1'b1;
          end else begin
            state_n = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (shift_en) begin
          cnt_n = cnt + CW'(1);
        end
        if (shift_en && (cnt == LAST_BIT)) begin
          state_n = ST_DONE;
        end else if (shift_en && (pend != '0)) begin
          head_n     = ser_msb;
          ser_shift  = 1'b1;
          pend_n     = pend - PW'(1);
          shift_en_n = 1'b1;
        end else if (cfg_valid && cfg_ready) begin
          // Accepting while the previous word's last bit shifts keeps the
          // chain moving with no bubble.
          head_n     = cfg_data[WORD_W-1];
          ser_load   = 1'b1;
          pend_n     = vb - PW'(1);
          issued_n   = issued + CW'(vb);
          shift_en_n = 1'b1;
        end
      end

      ST_READ: begin
        cnt_n     = cnt + CW'(1);
        des_shift = 1'b1;
        if (rcnt == W_LAST) begin
          rb_valid_n = 1'b1;
          rb_data_n  = captured;
          rcnt_n     = '0;
        end else begin
          rcnt_n = rcnt + PW'(1);
        end
        if (cnt == LAST_BIT) begin
          state_n = ST_DONE;
          if (rcnt != W_LAST) begin
            // Partial last word: left-justify the captured bits.
            rb_valid_n = 1'b1;
            rb_data_n  = captured << (W_LAST - rcnt);
          end
        end else begin
          shift_en_n = 1'b1;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    cfg_ready_n = (state_n == ST_LOAD) && (pend_n == '0) && (issued_n != CHAIN_C);
    busy_n      = (state_n != ST_IDLE);
    done_n      = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_ccff_loader.sv
module tb_ccff_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pReset, start, start8, readback, cfg_valid, cfg_valid8;
  logic [7:0] cfg_data;

  logic       cfg_ready, ccff_head, shift_en, ccff_tail, rb_valid, busy, done;
  logic [7:0] rb_data;
  logic       cfg_ready8, ccff_head8, shift_en8, ccff_tail8, rb_valid8, busy8, done8;
  logic [7:0] rb_data8;

  ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut (
    .prog_clk (prog_clk), .pReset (pReset), .start (start), .readback (readback),
    .cfg_data (cfg_data), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .ccff_head (ccff_head), .shift_en (shift_en), .ccff_tail (ccff_tail),
    .rb_data (rb_data), .rb_valid (rb_valid), .busy (busy), .done (done)
  );

  ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .prog_clk (prog_clk), .pReset (pReset), .start (start8), .readback (readback),
    .cfg_data (cfg_data), .cfg_valid (cfg_valid8), .cfg_ready (cfg_ready8),
    .ccff_head (ccff_head8), .shift_en (shift_en8), .ccff_tail (ccff_tail8),
    .rb_data (rb_data8), .rb_valid (rb_valid8), .busy (busy8), .done (done8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Chain models: shift toward the tail on every shift_en edge.
  logic [11:0] chain12 = '0;
  logic [7:0]  chain8  = '0;
  always @(posedge prog_clk) begin
    if (shift_en)  chain12 <= {chain12[10:0], ccff_head};
    if (shift_en8) chain8  <= {chain8[6:0], ccff_head8};
  end
  assign ccff_tail  = chain12[11];
  assign ccff_tail8 = chain8[7];

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Scoreboards: expected head bits and readback words.
  logic       hq12[$];
  logic [7:0] rq12[$];
  logic       hq8[$];
  logic [7:0] rq8[$];

  int nshift12 = 0, ndone12 = 0, nacc12 = 0, nrb12 = 0, first12 = -1, last12 = 0;
  int nshift8 = 0, ndone8 = 0, nacc8 = 0, nrb8 = 0;

  always @(negedge prog_clk) begin
    if (!busy) first12 = -1;
    if (shift_en) begin
      check("head12_pending", 32'(hq12.size() > 0), 1);
      if (hq12.size() > 0) check("head12", 32'(ccff_head), 32'(hq12.pop_front()));
      nshift12++;
      if (first12 < 0) first12 = cyc;
      last12 = cyc;
    end
    if (done) begin
      ndone12++;
      check("done12_lat", cyc - last12, 1);
    end
    if (cfg_valid && cfg_ready) nacc12++;
    if (rb_valid) begin
      nrb12++;
      check("rb12_pending", 32'(rq12.size() > 0), 1);
      if (rq12.size() > 0) check("rb12_data", 32'(rb_data), 32'(rq12.pop_front()));
    end
  end

  always @(negedge prog_clk) begin
    if (shift_en8) begin
      nshift8++;
      check("head8_pending", 32'(hq8.size() > 0), 1);
      if (hq8.size() > 0) check("head8", 32'(ccff_head8), 32'(hq8.pop_front()));
    end
    if (done8) ndone8++;
    if (cfg_valid8 && cfg_ready8) nacc8++;
    if (rb_valid8) begin
      nrb8++;
      check("rb8_pending", 32'(rq8.size() > 0), 1);
      if (rq8.size() > 0) check("rb8_data", 32'(rb_data8), 32'(rq8.pop_front()));
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  int left12 = 0;

  task automatic wait_ready12();
    int n;
    n = 0;
    while (!cfg_ready && n < 200) begin tick(); n++; end
    check("ready12_timeout", 32'(n < 200), 1);
  endtask

  task automatic wait_idle12();
    int n;
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    check("idle12_timeout", 32'(n < 500), 1);
  endtask

  task automatic send_word12(input logic [7:0] w);
    cfg_data  = w;
    cfg_valid = 1'b1;
    wait_ready12();
    for (int i = 7; i >= 0; i--) begin
      if (left12 > 0) begin
        hq12.push_back(w[i]);
        left12--;
      end
    end
    tick();
  endtask

  task automatic check_reset12(input string tag);
    check({tag, "_shift_en"}, 32'(shift_en), 0);
    check({tag, "_head"}, 32'(ccff_head), 0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    check({tag, "_rb_valid"}, 32'(rb_valid), 0);
    check({tag, "_rb_data"}, 32'(rb_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic do_load(input string tag, input int stall, input bit poke);
    int s0, d0, a0, span;
    s0 = nshift12; d0 = ndone12; a0 = nacc12;
    start = 1'b1; readback = 1'b0;
    tick();
    start = 1'b0;
    left12 = 12;
    send_word12(8'hA5);
    if (stall > 0) begin
      cfg_valid = 1'b0;
      wait_ready12();
      repeat (stall) tick();
      check({tag, "_gap_chain"}, 32'(chain12[7:0]), 32'h0A5);
    end
    if (poke) begin
      start = 1'b1; readback = 1'b1;
      tick();
      start = 1'b0; readback = 1'b0;
    end
    send_word12(8'h3C);
    cfg_valid = 1'b0;
    wait_idle12();
    span = last12 - first12 + 1;
    check({tag, "_chain"}, 32'(chain12), 32'hA53);
    check({tag, "_shifts"}, nshift12 - s0, 12);
    check({tag, "_dones"}, ndone12 - d0, 1);
    check({tag, "_words"}, nacc12 - a0, 2);
    check({tag, "_span"}, span, 12 + stall);
    check({tag, "_head_left"}, hq12.size(), 0);
  endtask

  task automatic do_read12(input logic [11:0] img);
    int s0, d0, r0;
    s0 = nshift12; d0 = ndone12; r0 = nrb12;
    for (int i = 11; i >= 0; i--) hq12.push_back(img[i]);
    rq12.push_back(img[11:4]);
    rq12.push_back({img[3:0], 4'h0});
    start = 1'b1; readback = 1'b1;
    tick();
    start = 1'b0; readback = 1'b0;
    wait_idle12();
    check("read_chain", 32'(chain12), 32'(img));
    check("read_shifts", nshift12 - s0, 12);
    check("read_dones", ndone12 - d0, 1);
    check("read_words", nrb12 - r0, 2);
    check("read_left", rq12.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int s0, d0, a0, r0, n;
    pReset = 1'b1; start = 1'b0; start8 = 1'b0; readback = 1'b0;
    cfg_valid = 1'b0; cfg_valid8 = 1'b0; cfg_data = 8'h00;
    #2 pReset = 1'b0;
    #1;
    check_reset12("rst0");
    check("rst0_busy8", 32'(busy8), 0);
    repeat (3) tick();
    pReset = 1'b1;
    repeat (2) tick();

    do_load("load", 0, 1'b0);
    do_read12(12'hA53);
    do_load("stall", 5, 1'b0);
    do_load("poke", 0, 1'b1);

    // Reset in the middle of a load.
    s0 = nshift12; d0 = ndone12;
    start = 1'b1; readback = 1'b0;
    tick();
    start = 1'b0;
    left12 = 12;
    send_word12(8'hA5);
    cfg_valid = 1'b0;
    n = 0;
    while ((nshift12 - s0) < 6 && n < 100) begin tick(); n++; end
    check("midrst_timeout", 32'(n < 100), 1);
    pReset = 1'b0;
    #1;
    check_reset12("midrst");
    check("midrst_chain6", 32'(chain12[5:0]), 32'h29);
    repeat (3) tick();
    check("midrst_no_done", ndone12 - d0, 0);
    hq12.delete();
    pReset = 1'b1;
    tick();
    do_load("reload", 0, 1'b0);

    // 8-bit chain: single word, then single readback word.
    a0 = nacc8; d0 = ndone8;
    start8 = 1'b1; readback = 1'b0;
    tick();
    start8 = 1'b0;
    cfg_data = 8'hFF; cfg_valid8 = 1'b1;
    n = 0;
    while (!cfg_ready8 && n < 50) begin tick(); n++; end
    check("l8_ready_timeout", 32'(n < 50), 1);
    for (int i = 0; i < 8; i++) hq8.push_back(1'b1);
    tick();
    check("l8_ready_drop", 32'(cfg_ready8), 0);
    n = 0;
    while (busy8 && n < 100) begin tick(); n++; end
    cfg_valid8 = 1'b0;
    check("l8_words", nacc8 - a0, 1);
    check("l8_dones", ndone8 - d0, 1);
    check("l8_chain", 32'(chain8), 32'hFF);

    r0 = nrb8; s0 = nshift8;
    rq8.push_back(8'hFF);
    for (int i = 0; i < 8; i++) hq8.push_back(chain8[7 - i]);
    start8 = 1'b1; readback = 1'b1;
    tick();
    start8 = 1'b0; readback = 1'b0;
    n = 0;
    while (busy8 && n < 100) begin tick(); n++; end
    check("r8_idle", 32'(busy8), 0);
    check("r8_words", nrb8 - r0, 1);
    check("r8_shifts", nshift8 - s0, 8);
    check("r8_chain", 32'(chain8), 32'hFF);
    check("r8_left", rq8.size(), 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
